soc_top: RTL and testbench
==========================

# soc_top

Minimal single-clock system-on-chip top level: a tiny accumulator sequencer executes a fixed 16-entry instruction ROM and drives two 32-bit registered GPIO output ports. It is the top of the system simulation, so the bench only supplies clock and reset and watches `gpio`/`gpio1`. The block has no bus, no memory-mapped peripherals and no inputs beyond clock and reset.

## Interface
- Parameters: none.
- `clk`, input, 1 bit. Single clock; all state updates on its rising edge.
- `rst`, input, 1 bit. Reset, synchronous and active-high.
- `gpio`, output, 32 bits. Registered GPIO port 0, written by OUT0.
- `gpio1`, output, 32 bits. Registered GPIO port 1, written by OUT1.

## Operation
- **State:**
  - `pc`: 4 bits.
  - `acc`: 32 bits.
  - `cnt`: 12 bits.
  - `halted`: 1 bit.
  - `gpio`, `gpio1`: 32-bit output registers.
- **Reset:** `rst`=1 at a rising edge clears all state to 0.
- **Instruction format:** 16 bits, `op`=[15:12], `imm`=[11:0]. One instruction executes per edge while not halted. Otherwise `pc` = `pc`+1, wrapping 15→0.
- **Opcodes** (zext = zero-extend; sext = sign-extend; all arithmetic mod 2^32):
  - 0x0 NOP.
  - 0x1 LDI: `acc` = zext(`imm`).
  - 0x2 ADDI: `acc` = `acc` + sext(`imm`).
  - 0x3 SHL: `acc` = `acc` << `imm`[4:0].
  - 0x4 XORI: `acc` = `acc` ^ zext(`imm`).
  - 0x5 OUT0: `gpio` = `acc`.
  - 0x6 OUT1: `gpio1` = `acc`.
  - 0x7 JMP: `pc` = `imm`[3:0].
  - 0x8 LDC: `cnt` = `imm`.
  - 0x9 DJNZ: `cnt` = `cnt`−1, wrapping mod 2^12. If the new `cnt` ≠ 0, `pc` = `imm`[3:0]; else `pc`+1.
  - 0xF HALT: `halted` = 1; `pc` frozen.
  - Other opcodes: NOP.
- **Halt:** once halted, nothing changes until reset.
- **Fixed ROM contents** (address: instruction):
  - 0: LDI 0
  - 1: OUT0
  - 2: OUT1
  - 3: LDC 10
  - 4: ADDI 1
  - 5: OUT0
  - 6: DJNZ 4
  - 7: LDI 0x0A5
  - 8: OUT1
  - 9: SHL 4
  - 10: XORI 0x00F
  - 11: OUT0
  - 12: HALT
  - 13–15: NOP
- **Boundary cases:**
  - DJNZ with `cnt`=0 wraps to 0xFFF and branches.
  - ADDI of 0xFFF decrements `acc`.
  - `acc` overflow wraps silently.
  - Reset asserted mid-program, including while halted, restarts from `pc`=0 on the next edge with `rst`=0.

## Timing
- Edges are numbered E1, E2, …, counting rising edges with `rst`=0 after reset. Each instruction completes at its edge; register outputs are visible right after.
- `gpio`, `gpio1` reset value 0; they hold until the next OUT0/OUT1.
- Program trace:
  - E1: LDI.
  - E2: OUT0, `gpio`=0.
  - E3: OUT1, `gpio1`=0.
  - E4: LDC, `cnt`=10.
- Loop iteration i = 1..10:
  - ADDI at E(2+3i).
  - OUT0 at E(3+3i), `gpio`=i.
  - DJNZ at E(4+3i).
- E34: final DJNZ, `cnt` reaches 0, falls through.
- E35: LDI, `acc`=0xA5.
- E36: OUT1, `gpio1`=0x000000A5.
- E37: SHL, `acc`=0xA50.
- E38: XORI, `acc`=0xA5F.
- E39: OUT0, `gpio`=0x00000A5F.
- E40: HALT; outputs stable forever after.
- No combinational path from `rst` to outputs; all outputs change only at clock edges.

## Test plan
- **Reset:** hold `rst`=1 for 10 cycles → `gpio`=`gpio1`=0 throughout; no change while `rst`=1.
- **Counting loop:** release reset → `gpio` steps 1,2,…,10 at E6,E9,…,E33; `gpio1` stays 0 until E36.
- **Final values:** run to E40 and beyond (e.g. 1 ms at 100 MHz) → `gpio`=0x00000A5F, `gpio1`=0x000000A5, stable for all later edges.
- **Mid-run reset:** assert `rst` for 1 edge at E20 → outputs 0 next edge; after release the full sequence repeats from E1 with identical timing.
- **Reset while halted:** assert reset after E45 → program re-executes and again ends with 0xA5F/0xA5.
- **Unit-level directed checks** via a ROM override in a unit bench:
  - DJNZ with `cnt`=0 → branches, `cnt`=0xFFF.
  - ADDI 0xFFF on `acc`=0 → `acc`=0xFFFFFFFF.

Source files
------------

// File: rtl/soc_top.sv
// -----------------------------------------------------------------------------
// soc_top
//   Minimal single-clock SoC top: an accumulator sequencer steps through a
//   fixed 16-entry instruction ROM and drives two registered GPIO ports.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous active-high reset, clears all state
//   gpio   out  32  GPIO port 0, written by OUT0
//   gpio1  out  32  GPIO port 1, written by OUT1
//
// Instruction format: op = [15:12], imm = [11:0].
// -----------------------------------------------------------------------------
module soc_top (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] gpio,
   output logic [31:0] gpio1
);

   typedef enum logic {
      ST_RUN,
      ST_HALT
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LDI  = 4'h1,
      OP_ADDI = 4'h2,
      OP_SHL  = 4'h3,
      OP_XORI = 4'h4,
      OP_OUT0 = 4'h5,
      OP_OUT1 = 4'h6,
      OP_JMP  = 4'h7,
      OP_LDC  = 4'h8,
      OP_DJNZ = 4'h9,
      OP_RSVA = 4'hA,
      OP_RSVB = 4'hB,
      OP_RSVC = 4'hC,
      OP_RSVD = 4'hD,
      OP_RSVE = 4'hE,
      OP_HALT = 4'hF
   } op_t;

   state_t      state_q, state_d;
   logic [3:0]  pc_q,    pc_d;
   logic [31:0] acc_q,   acc_d;
   logic [11:0] cnt_q,   cnt_d;
   logic [31:0] gpio_q,  gpio_d;
   logic [31:0] gpio1_q, gpio1_d;

   logic [15:0] instr;
   op_t         op;
   logic [11:0] imm;
   logic [11:0] cnt_dec;

   // Fixed program ROM
   always_comb begin
      instr = 16'h0000;
      unique case (pc_q)
         4'd0:    instr = {OP_LDI,  12'h000};
         4'd1:    instr = {OP_OUT0, 12'h000};
         4'd2:    instr = {OP_OUT1, 12'h000};
         4'd3:    instr = {OP_LDC,  12'd10};
         4'd4:    instr = {OP_ADDI, 12'h001};
         4'd5:    instr = {OP_OUT0, 12'h000};
         4'd6:    instr = {OP_DJNZ, 12'h004};
         4'd7:    instr = {OP_LDI,  12'h0A5};
         4'd8:    instr = {OP_OUT1, 12'h000};
         4'd9:    instr = {OP_SHL,  12'h004};
         4'd10:   instr = {OP_XORI, 12'h00F};
         4'd11:   instr = {OP_OUT0, 12'h000};
         4'd12:   instr = {OP_HALT, 12'h000};
         default: instr = {OP_NOP,  12'h000};
      endcase
   end

   assign op      = op_t'(instr[15:12]);
   assign imm     = instr[11:0];
   assign cnt_dec = cnt_q - 12'd1;

   // Next-state / execute
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      gpio_d  = gpio_q;
      gpio1_d = gpio1_q;

      if (state_q == ST_RUN) begin
         pc_d = pc_q + 4'd1;
         case (op)
            OP_LDI:  acc_d   = {20'd0, imm};
            OP_ADDI: acc_d   = acc_q + {{20{imm[11]}}, imm};
            OP_SHL:  acc_d   = acc_q << imm[4:0];
            OP_XORI: acc_d   = acc_q ^ {20'd0, imm};
            OP_OUT0: gpio_d  = acc_q;
            OP_OUT1: gpio1_d = acc_q;
            OP_JMP:  pc_d    = imm[3:0];
            OP_LDC:  cnt_d   = imm;
            OP_DJNZ: begin
               // Branch decision uses the decremented count, so cnt=0 wraps and branches.
               cnt_d = cnt_dec;
               if (cnt_dec != '0) begin
                  pc_d = imm[3:0];
               end
            end
            OP_HALT: begin
               state_d = ST_HALT;
               pc_d    = pc_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         pc_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         gpio_q  <= '0;
         gpio1_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         gpio_q  <= gpio_d;
         gpio1_q <= gpio1_d;
      end
   end

   assign gpio  = gpio_q;
   assign gpio1 = gpio1_q;

endmodule

// File: tb/tb_soc_top.sv
// -----------------------------------------------------------------------------
// tb_soc_top
//   System-level bench for soc_top. Expected GPIO values come from the
//   program timeline expressed as a function of the edge count since the last
//   reset (rst=0 edges), independent of the sequencer's internal state.
// -----------------------------------------------------------------------------
module tb_soc_top;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] gpio;
   logic [31:0] gpio1;

   int unsigned edge_n = 0;
   int          n_vec  = 0;
   int          n_err  = 0;

   soc_top dut (
      .clk   (clk),
      .rst   (rst),
      .gpio  (gpio),
      .gpio1 (gpio1)
   );

   always #5 clk = ~clk;

   // gpio: 0 until E6, then i at E(3+3i) for i=1..10, 0xA5F from E39 on.
   function automatic logic [31:0] exp_gpio(int unsigned e);
      int unsigned i;
      if (e < 6)   return 32'd0;
      if (e >= 39) return 32'h0000_0A5F;
      i = (e - 3) / 3;
      if (i > 10) i = 10;
      return 32'(i);
   endfunction

   // gpio1: 0 until E36, then 0xA5.
   function automatic logic [31:0] exp_gpio1(int unsigned e);
      return (e >= 36) ? 32'h0000_00A5 : 32'd0;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s edge=%0d got=0x%08h exp=0x%08h", tag, edge_n, got, exp);
      end
   endtask

   // One clock edge with the given reset level, then check both ports.
   task automatic step(input logic r);
      rst = r;
      @(posedge clk);
      if (r) edge_n = 0;
      else   edge_n++;
      #1;
      check_eq("gpio",  gpio,  exp_gpio(edge_n));
      check_eq("gpio1", gpio1, exp_gpio1(edge_n));
   endtask

   initial begin
      int unsigned nrst;
      int unsigned nrun;

      // Power-on reset held 10 cycles
      repeat (10) step(1'b1);

      // Run to E19, reset on the 20th edge, then full run
      repeat (19) step(1'b0);
      step(1'b1);
      repeat (60) step(1'b0);

      // Reset while halted, rerun and watch outputs stay put long after HALT
      step(1'b1);
      repeat (1000) step(1'b0);

      // Random reset pulses at arbitrary program points
      for (int k = 0; k < 40; k++) begin
         nrst = $urandom_range(1, 3);
         nrun = $urandom_range(1, 60);
         repeat (nrst) step(1'b1);
         repeat (nrun) step(1'b0);
      end

      // Finish cleanly
      repeat (50) step(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
